if_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the PC and fetches from an instruction memory with variable latency using a req/ack handshake.
- Holds the fetched word in an instruction register and presents it to decode with a valid/ready handshake.
- Computes the next PC as PC+4 or the branch target PC+4+(Immed<<2), using the sign-extended immediate returned by decode.

---
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency
// instruction memory over a req/ack handshake, and hands the fetched word
// to decode over a valid/ready handshake. Every output is a register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PC_sel,
    input  logic [31:0] Immed,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    input  logic        Dec_Ready,
    output logic [31:0] PC,
    output logic [31:0] Fetch_Count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Word-aligned reset PC: the low two bits are always cleared.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [31:0] count_q, count_d;

    // Sequential or branch successor; the word offset is shifted into a byte
    // offset and the sum wraps modulo 2^32, so negative offsets branch back.
    function automatic logic [31:0] calc_next_pc(input logic [31:0] pc,
                                                 input logic        sel,
                                                 input logic [31:0] immed);
        logic [31:0] seq_pc;
        seq_pc = pc + 32'd4;
        if (sel) begin
            calc_next_pc = seq_pc + {immed[29:0], 2'b00};
        end else begin
            calc_next_pc = seq_pc;
        end
    endfunction

    // Next-state logic: every register holds unless the FSM decides otherwise.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                req_d   = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                // Request and address stay put until memory answers.
                if (IMem_Ack) begin
                    instr_d = IMem_Data;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end else begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                // Memory acks are ignored here, so Instr cannot be clobbered.
                if (valid_q && Dec_Ready) begin
                    pc_d    = calc_next_pc(pc_q, PC_sel, Immed);
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                // Illegal encoding: drop any outstanding work and restart.
                valid_d = 1'b0;
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC_ALIGNED;
            instr_q <= 32'h0000_0000;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            count_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            count_q <= count_d;
        end
    end

    assign IMem_Req    = req_q;
    assign IMem_Addr   = pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign Instr_Valid = valid_q;
    assign Fetch_Count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a directed table of transfers, hand
// sequences for reset and mid-fetch reset, then randomized traffic checked
// against a simple PC/count/instruction model.
module tb_if_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PC_sel;
    logic [31:0] Immed;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_Data;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Dec_Ready;
    logic [31:0] PC;
    logic [31:0] Fetch_Count;

    if_stage #(.RESET_PC(32'h0000_0040)) dut (
        .Clk(Clk), .Reset(Reset), .PC_sel(PC_sel), .Immed(Immed),
        .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack),
        .IMem_Data(IMem_Data), .Instr(Instr), .Instr_Valid(Instr_Valid),
        .Dec_Ready(Dec_Ready), .PC(PC), .Fetch_Count(Fetch_Count)
    );

    always #5 Clk = ~Clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_instr;

    typedef struct {
        logic        sel;
        logic [31:0] imm;
        int          stall;
        logic [31:0] exp_pc;
        int          ack_wait;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[9];
    int   xfer_cyc[9];

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Wait cycles with request held, then ack with data; ready is a don't-care here.
    task automatic do_fetch(input logic [31:0] data, input int ack_wait, input logic rdy);
        Dec_Ready = rdy;
        for (int w = 0; w < ack_wait; w++) begin
            IMem_Ack = 1'b0;
            chk("fetch_req_held", {31'd0, IMem_Req}, 32'd1);
            chk("fetch_addr_held", IMem_Addr, m_pc);
            tick();
        end
        chk("fetch_req", {31'd0, IMem_Req}, 32'd1);
        chk("fetch_addr", IMem_Addr, m_pc);
        IMem_Ack  = 1'b1;
        IMem_Data = data;
        tick();
        IMem_Ack  = 1'b0;
        Dec_Ready = 1'b0;
        m_instr   = data;
        chk("fetch_instr", Instr, m_instr);
        chk("fetch_valid", {31'd0, Instr_Valid}, 32'd1);
        chk("fetch_req_drop", {31'd0, IMem_Req}, 32'd0);
        chk("fetch_pc", PC, m_pc);
    endtask

    // Decode stalls (with a stray ack in the first stall cycle), then accepts.
    task automatic do_transfer(input logic sel, input logic [31:0] imm, input int stall);
        for (int s = 0; s < stall; s++) begin
            Dec_Ready = 1'b0;
            IMem_Ack  = (s == 0);
            IMem_Data = 32'hDEAD_BEEF;
            tick();
            chk("stall_instr", Instr, m_instr);
            chk("stall_valid", {31'd0, Instr_Valid}, 32'd1);
            chk("stall_pc", PC, m_pc);
            chk("stall_count", Fetch_Count, m_cnt);
            chk("stall_req", {31'd0, IMem_Req}, 32'd0);
        end
        IMem_Ack  = 1'b0;
        PC_sel    = sel;
        Immed     = imm;
        Dec_Ready = 1'b1;
        tick();
        Dec_Ready = 1'b0;
        m_pc  = sel ? (m_pc + 32'd4 + imm * 32'd4) : (m_pc + 32'd4);
        m_cnt = m_cnt + 32'd1;
        chk("xfer_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("xfer_req", {31'd0, IMem_Req}, 32'd1);
        chk("xfer_pc", PC, m_pc);
        chk("xfer_addr", IMem_Addr, m_pc);
        chk("xfer_count", Fetch_Count, m_cnt);
        chk("xfer_instr_kept", Instr, m_instr);
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0040;
        m_cnt   = 32'd0;
        m_instr = 32'd0;
    endtask

    initial begin
        Reset = 1'b0; PC_sel = 1'b0; Immed = 32'd0;
        IMem_Ack = 1'b0; IMem_Data = 32'd0; Dec_Ready = 1'b0;
        model_reset();

        //               sel   imm            stall exp_pc         wait data
        tbl[0] = '{1'b0, 32'h0000_0000, 0, 32'h0000_0044, 0, 32'h1111_0001};
        tbl[1] = '{1'b0, 32'h0000_0000, 0, 32'h0000_0048, 0, 32'h1111_0002};
        tbl[2] = '{1'b0, 32'h0000_0000, 0, 32'h0000_004C, 0, 32'h1111_0003};
        tbl[3] = '{1'b1, 32'h0000_002C, 0, 32'h0000_0100, 0, 32'h1111_0004};
        tbl[4] = '{1'b1, 32'h0000_0003, 0, 32'h0000_0110, 0, 32'h1111_0005};
        tbl[5] = '{1'b1, 32'hFFFF_FFFB, 0, 32'h0000_0100, 0, 32'h1111_0006};
        tbl[6] = '{1'b1, 32'hFFFF_FFFE, 0, 32'h0000_00FC, 0, 32'h1111_0007};
        tbl[7] = '{1'b1, 32'hFFFF_FFBF, 0, 32'hFFFF_FFFC, 5, 32'h1111_0008};
        tbl[8] = '{1'b0, 32'h0000_0000, 4, 32'h0000_0000, 0, 32'h1111_0009};

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) tick();
        chk("rst_req", {31'd0, IMem_Req}, 32'd0);
        chk("rst_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("rst_instr", Instr, 32'd0);
        chk("rst_pc", PC, 32'h0000_0040);
        chk("rst_count", Fetch_Count, 32'd0);
        Reset = 1'b1;
        chk("rel_req_low", {31'd0, IMem_Req}, 32'd0);
        tick();
        chk("rel_req_rise", {31'd0, IMem_Req}, 32'd1);
        chk("rel_addr", IMem_Addr, 32'h0000_0040);
        do_fetch(32'h2001_0005, 0, 1'b0);
        chk("first_instr", Instr, 32'h2001_0005);

        // Directed table: transfer, then refetch from the new PC
        for (int i = 0; i < 9; i++) begin
            do_transfer(tbl[i].sel, tbl[i].imm, tbl[i].stall);
            xfer_cyc[i] = cyc;
            chk($sformatf("tbl%0d_pc", i), IMem_Addr, tbl[i].exp_pc);
            if (i == 3) chk("count_after_4", Fetch_Count, 32'd4);
            do_fetch(tbl[i].data, tbl[i].ack_wait, 1'b0);
        end
        chk("seq_2cyc_per_instr", xfer_cyc[2] - xfer_cyc[0], 32'd4);

        // Branch to 0x200, then reset while that fetch is pending
        do_transfer(1'b1, 32'h0000_007F, 1);
        chk("pc_200", PC, 32'h0000_0200);
        tick();
        Reset = 1'b0;
        tick();
        model_reset();
        Reset     = 1'b1;
        IMem_Ack  = 1'b1;
        IMem_Data = 32'hCAFE_F00D;
        tick();
        IMem_Ack  = 1'b0;
        chk("mid_rst_instr", Instr, 32'd0);
        chk("mid_rst_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("mid_rst_pc", PC, 32'h0000_0040);
        chk("mid_rst_count", Fetch_Count, 32'd0);
        chk("mid_rst_req_restart", {31'd0, IMem_Req}, 32'd1);

        // Randomized traffic against the model
        do_fetch($urandom(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 40; i++) begin
            do_transfer(1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 3));
            do_fetch($urandom(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
